// File: rtl/bus_demux2_rx_pkg.sv
// rtl/bus_demux2_rx_pkg.sv - shared widths, depth default and channel codes for the bus receiver
package bus_demux2_rx_pkg;

    localparam int BUS_WIDTH = 4;
    localparam int DEPTH_DEF = 2;
    localparam int CNTW_DEF  = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/bus_demux2_rx_if.sv
// rtl/bus_demux2_rx_if.sv - bus input side and both output channels of the receiver
interface bus_demux2_rx_if
    import bus_demux2_rx_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int CNTW  = CNTW_DEF
);

    logic [WIDTH-1:0] bus_d;
    logic             bus_sel;
    logic             bus_valid;
    logic             bus_ready;

    logic [WIDTH-1:0] y0_d;
    logic             y0_valid;
    logic             y0_ready;
    logic [WIDTH-1:0] y1_d;
    logic             y1_valid;
    logic             y1_ready;

    logic [CNTW-1:0]  cnt0;
    logic [CNTW-1:0]  cnt1;

    // master: bus drivers plus downstream consumers; slave: the receiver
    modport master (
        output bus_d, bus_sel, bus_valid, y0_ready, y1_ready,
        input  bus_ready, y0_d, y0_valid, y1_d, y1_valid, cnt0, cnt1
    );

    modport slave (
        input  bus_d, bus_sel, bus_valid, y0_ready, y1_ready,
        output bus_ready, y0_d, y0_valid, y1_d, y1_valid, cnt0, cnt1
    );

endinterface

// File: rtl/bus_demux2_rx_fifo.sv
// rtl/bus_demux2_rx_fifo.sv - rx_fifo: per-channel buffer with registered head word
module rx_fifo
    import bus_demux2_rx_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_demux2_rx.sv
// rtl/bus_demux2_rx.sv - receive end of the 2-source bus: steers words into two buffered channels
module bus_demux2_rx
    import bus_demux2_rx_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    bus_demux2_rx_if.slave bus
);

    logic            full0;
    logic            full1;
    logic            empty0;
    logic            empty1;
    logic            push0;
    logic            push1;
    logic            accept;
    logic [CNTW-1:0] cnt0_q;
    logic [CNTW-1:0] cnt1_q;

    // full is judged before any same-cycle pop, so a pop never frees room for the push
    assign bus.bus_ready = (bus.bus_sel == CH1) ? ~full1 : ~full0;
    assign accept        = bus.bus_valid & bus.bus_ready;
    assign push0         = accept & (bus.bus_sel == CH0);
    assign push1         = accept & (bus.bus_sel == CH1);

    assign bus.y0_valid = ~empty0;
    assign bus.y1_valid = ~empty1;

    rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .pop   (bus.y0_ready),
        .din   (bus.bus_d),
        .dout  (bus.y0_d),
        .empty (empty0),
        .full  (full0)
    );

    rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .pop   (bus.y1_ready),
        .din   (bus.bus_d),
        .dout  (bus.y1_d),
        .empty (empty1),
        .full  (full1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (push0) begin
                cnt0_q <= cnt0_q + CNTW'(1);
            end
            if (push1) begin
                cnt1_q <= cnt1_q + CNTW'(1);
            end
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;

endmodule

// File: tb/tb_bus_demux2_rx.sv
// tb/tb_bus_demux2_rx.sv - randomized and directed bench for bus_demux2_rx against a queue model
module tb_bus_demux2_rx;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNTW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [CNTW-1:0]  m_cnt0;
    logic [CNTW-1:0]  m_cnt1;

    bus_demux2_rx_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    bus_demux2_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_cnt0 = '0;
        m_cnt1 = '0;
    endtask

    // Starts and ends at a falling edge; checks every output against the model
    task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1);
        bit acc;
        bit p0;
        bit p1;
        int occ;
        bus.bus_valid = v;
        bus.bus_sel   = s;
        bus.bus_d     = d;
        bus.y0_ready  = r0;
        bus.y1_ready  = r1;
        #1;
        occ = s ? q1.size() : q0.size();
        chk("bus_ready", 32'(bus.bus_ready), 32'(occ < DEPTH));
        chk("y0_valid", 32'(bus.y0_valid), 32'(q0.size() != 0));
        chk("y1_valid", 32'(bus.y1_valid), 32'(q1.size() != 0));
        if (q0.size() != 0) chk("y0_d", 32'(bus.y0_d), 32'(q0[0]));
        if (q1.size() != 0) chk("y1_d", 32'(bus.y1_d), 32'(q1[0]));
        chk("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
        chk("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
        acc = v && (occ < DEPTH);
        p0  = r0 && (q0.size() != 0);
        p1  = r1 && (q1.size() != 0);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (s) begin
                q1.push_back(d);
                m_cnt1 = m_cnt1 + 1'b1;
            end else begin
                q0.push_back(d);
                m_cnt0 = m_cnt0 + 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Asserts rst mid-cycle, checks the cleared state, releases at a falling edge
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_y0_valid", 32'(bus.y0_valid), 32'd0);
        chk("rst_y1_valid", 32'(bus.y1_valid), 32'd0);
        chk("rst_cnt0", 32'(bus.cnt0), 32'd0);
        chk("rst_cnt1", 32'(bus.cnt1), 32'd0);
        bus.bus_valid = 1'b0;
        bus.y0_ready  = 1'b0;
        bus.y1_ready  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        chk("rst_bus_ready", 32'(bus.bus_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bus.bus_d     = '0;
        bus.bus_sel   = 1'b0;
        bus.bus_valid = 1'b0;
        bus.y0_ready  = 1'b0;
        bus.y1_ready  = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("init_y0_d", 32'(bus.y0_d), 32'd0);
        chk("init_y1_d", 32'(bus.y1_d), 32'd0);
        @(negedge clk);

        // routing
        cycle(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
        chk("route_y0_d", 32'(bus.y0_d), 32'hA);
        chk("route_y0_valid", 32'(bus.y0_valid), 32'd1);
        cycle(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
        chk("route_y1_d", 32'(bus.y1_d), 32'h5);
        chk("route_cnt0", 32'(bus.cnt0), 32'd1);
        chk("route_cnt1", 32'(bus.cnt1), 32'd1);

        // reset in the middle of traffic with both channels holding words
        cycle(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
        do_reset();

        // full and stall on ch0
        cycle(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
        chk("stall_ready", 32'(bus.bus_ready), 32'd0);
        chk("stall_cnt0", 32'(bus.cnt0), 32'd2);
        chk("stall_head3", 32'(bus.y0_d), 32'h3);
        cycle(1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
        chk("stall_pop_cnt0", 32'(bus.cnt0), 32'd2);
        chk("stall_head6", 32'(bus.y0_d), 32'h6);
        cycle(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
        chk("stall_accept_cnt0", 32'(bus.cnt0), 32'd3);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("stall_head9", 32'(bus.y0_d), 32'h9);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("stall_drained", 32'(bus.y0_valid), 32'd0);

        // simultaneous push and pop on one channel, then across channels
        do_reset();
        cycle(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'hC, 1'b1, 1'b0);
        chk("simul_head", 32'(bus.y0_d), 32'hC);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("simul_occ1", 32'(bus.y0_valid), 32'd0);
        cycle(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
        chk("cross_pop0", 32'(bus.y0_valid), 32'd0);
        chk("cross_push1", 32'(bus.y1_d), 32'h7);
        chk("cross_cnt1", 32'(bus.cnt1), 32'd1);

        // counter wrap on ch1
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) chk("wrap_pre", 32'(bus.cnt1), 32'd255);
            cycle(1'b1, 1'b1, 4'(i), 1'b0, 1'b1);
        end
        chk("wrap_cnt1", 32'(bus.cnt1), 32'd0);
        chk("wrap_last_valid", 32'(bus.y1_valid), 32'd1);
        chk("wrap_last_d", 32'(bus.y1_d), 32'hF);

        // random traffic
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 2 * DEPTH; n++) begin
            cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        end
        chk("final_empty0", 32'(bus.y0_valid), 32'd0);
        chk("final_empty1", 32'(bus.y1_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
